// File: rtl/game2_display.sv
// Scanned 8-digit 7-segment display and LED driver for the two-player rope game.
// Shows a countdown, both scores with the rope position, and a blinking winner.
module game2_display #(
  parameter int BLINK_HALF = 500
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [2:0] SCREEN,
  input  logic [2:0] LOCATION,
  input  logic [2:0] COUNT_DOWN,
  input  logic [3:0] P1_100,
  input  logic [3:0] P1_10,
  input  logic [3:0] P1_1,
  input  logic [3:0] P2_100,
  input  logic [3:0] P2_10,
  input  logic [3:0] P2_1,
  output logic [7:0] SEG_COM,
  output logic [7:0] SEG_DATA,
  output logic [7:0] LED
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [2:0] SCR_CD   = 3'b001;
  localparam logic [2:0] SCR_PLAY = 3'b010;
  localparam logic [2:0] SCR_OVER = 3'b100;

  typedef enum logic [1:0] {WIN_TIE, WIN_P1, WIN_P2} winner_t;

  logic [2:0]    idx;
  logic [2:0]    prev_screen;
  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          on_q, on_d, on_eff;
  winner_t       win_q, win_d, win_eff, win_cmp;
  logic          entry, wrap, is_dash, blank;
  logic [3:0]    digit_val;
  logic [7:0]    score_data, data_d, led_d;
  logic [11:0]   p1_score, p2_score;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // On the entry edge the freshly compared winner and a restarted blink are
  // used directly, so the first game-over frame already shows the new result.
  always_comb begin
    p1_score = {P1_100, P1_10, P1_1};
    p2_score = {P2_100, P2_10, P2_1};
    entry    = (SCREEN == SCR_OVER) && (prev_screen != SCR_OVER);
    if (p1_score > p2_score)      win_cmp = WIN_P1;
    else if (p2_score > p1_score) win_cmp = WIN_P2;
    else                          win_cmp = WIN_TIE;
    win_eff = entry ? win_cmp : win_q;
    cnt_eff = entry ? '0 : cnt_q;
    on_eff  = entry ? 1'b1 : on_q;
    wrap    = (cnt_eff == CW'(BLINK_HALF - 1));
  end

  // NOTE: every output of this block is given a default first, so no latch is inferred.
  always_comb begin
    is_dash   = 1'b0;
    digit_val = 4'd0;
    case (idx)
      3'd0: digit_val = P1_100;
      3'd1: digit_val = P1_10;
      3'd2: digit_val = P1_1;
      3'd5: digit_val = P2_100;
      3'd6: digit_val = P2_10;
      3'd7: digit_val = P2_1;
      default: is_dash = 1'b1;
    endcase
    score_data = is_dash ? 8'h40 : seg7(digit_val);

    blank = !on_eff && ((win_eff == WIN_TIE) ||
                        (win_eff == WIN_P1 && idx <= 3'd2) ||
                        (win_eff == WIN_P2 && idx >= 3'd5));

    data_d = 8'h00;
    led_d  = 8'h00;
    cnt_d  = '0;
    on_d   = 1'b1;
    win_d  = win_q;
    case (SCREEN)
      SCR_CD: begin
        if (idx == 3'd7) data_d = seg7({1'b0, COUNT_DOWN});
      end
      SCR_PLAY: begin
        data_d = score_data;
        if (LOCATION != 3'd7) led_d = 8'b1 << LOCATION;
      end
      SCR_OVER: begin
        data_d = blank ? 8'h00 : score_data;
        if (on_eff) begin
          case (win_eff)
            WIN_P1:  led_d = 8'h0F;
            WIN_P2:  led_d = 8'hF0;
            default: led_d = 8'hFF;
          endcase
        end
        cnt_d = wrap ? '0 : cnt_eff + CW'(1);
        on_d  = wrap ? ~on_eff : on_eff;
        win_d = win_eff;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      idx         <= 3'd0;
      prev_screen <= 3'b000;
      cnt_q       <= '0;
      on_q        <= 1'b1;
      win_q       <= WIN_TIE;
      SEG_COM     <= 8'hFF;
      SEG_DATA    <= 8'h00;
      LED         <= 8'h00;
    end else begin
      idx         <= idx + 3'd1;
      prev_screen <= SCREEN;
      cnt_q       <= cnt_d;
      on_q        <= on_d;
      win_q       <= win_d;
      SEG_COM     <= ~(8'b1 << idx);
      SEG_DATA    <= data_d;
      LED         <= led_d;
    end
  end

endmodule

// File: tb/tb_game2_display.sv
// Directed bench for game2_display: scan, play, game-over blink, tie,
// bad BCD, reset mid-blink and re-entry, with hand-derived expectations.
module tb_game2_display;

  localparam int T_TIE = 0;
  localparam int T_P1  = 1;
  localparam int T_P2  = 2;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [2:0] SCREEN = 3'b001;
  logic [2:0] LOCATION = 3'd3;
  logic [2:0] COUNT_DOWN = 3'd0;
  logic [3:0] P1_100 = 0, P1_10 = 0, P1_1 = 0;
  logic [3:0] P2_100 = 0, P2_10 = 0, P2_1 = 0;
  logic [7:0] SEG_COM, SEG_DATA, LED;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] dig = 3'd0;
  logic [2:0] nxt = 3'd0;

  game2_display #(.BLINK_HALF(500)) dut (
    .CLK(CLK), .RESETN(RESETN), .SCREEN(SCREEN), .LOCATION(LOCATION),
    .COUNT_DOWN(COUNT_DOWN),
    .P1_100(P1_100), .P1_10(P1_10), .P1_1(P1_1),
    .P2_100(P2_100), .P2_10(P2_10), .P2_1(P2_1),
    .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 8'h3F; 4'd1: seg = 8'h06; 4'd2: seg = 8'h5B; 4'd3: seg = 8'h4F;
      4'd4: seg = 8'h66; 4'd5: seg = 8'h6D; 4'd6: seg = 8'h7D; 4'd7: seg = 8'h07;
      4'd8: seg = 8'h7F; 4'd9: seg = 8'h6F;
      default: seg = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_data(input logic [2:0] d, input int w, input bit on);
    logic [7:0] s;
    case (d)
      3'd0: s = seg(P1_100);
      3'd1: s = seg(P1_10);
      3'd2: s = seg(P1_1);
      3'd5: s = seg(P2_100);
      3'd6: s = seg(P2_10);
      3'd7: s = seg(P2_1);
      default: s = 8'h40;
    endcase
    case (SCREEN)
      3'b001: exp_data = (d == 3'd7) ? seg({1'b0, COUNT_DOWN}) : 8'h00;
      3'b010: exp_data = s;
      3'b100: begin
        if (!on && (w == T_TIE || (w == T_P1 && d <= 3'd2) || (w == T_P2 && d >= 3'd5)))
          exp_data = 8'h00;
        else
          exp_data = s;
      end
      default: exp_data = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_led(input int w, input bit on);
    case (SCREEN)
      3'b010: exp_led = (LOCATION == 3'd7) ? 8'h00 : (8'b1 << LOCATION);
      3'b100: exp_led = !on ? 8'h00 : (w == T_P1) ? 8'h0F : (w == T_P2) ? 8'hF0 : 8'hFF;
      default: exp_led = 8'h00;
    endcase
  endfunction

  // One clock edge; afterwards dig is the digit the outputs now refer to.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (RESETN) begin
      dig = nxt;
      nxt = nxt + 3'd1;
    end else begin
      nxt = 3'd0;
    end
  endtask

  task automatic run(input int n, input int w, input bit on, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_com"},  SEG_COM,  ~(8'b1 << dig));
      check({tag, "_data"}, SEG_DATA, exp_data(dig, w, on));
      check({tag, "_led"},  LED,      exp_led(w, on));
    end
  endtask

  task automatic set_scores(input logic [11:0] p1, input logic [11:0] p2);
    {P1_100, P1_10, P1_1} = p1;
    {P2_100, P2_10, P2_1} = p2;
  endtask

  initial begin
    tick();
    tick();
    check("rst_com", SEG_COM, 8'hFF);
    check("rst_data", SEG_DATA, 8'h00);
    check("rst_led", LED, 8'h00);

    // Countdown scan: digit 7 shows 2, the rest blank
    SCREEN = 3'b001; COUNT_DOWN = 3'd2; RESETN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("scan_com", SEG_COM, ~(8'b1 << i));
      check("scan_data", SEG_DATA, (i == 7) ? 8'h5B : 8'h00);
      check("scan_led", LED, 8'h00);
    end

    // Play screen, fixed expected pattern
    SCREEN = 3'b010; LOCATION = 3'd5;
    set_scores(12'h042, 12'h039);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat [8] = '{8'h3F, 8'h66, 8'h5B, 8'h40, 8'h40, 8'h3F, 8'h4F, 8'h6F};
      tick();
      check("play_data", SEG_DATA, pat[i]);
      check("play_led", LED, 8'h20);
    end
    LOCATION = 3'd7;
    tick();
    check("play_loc7_led", LED, 8'h00);
    LOCATION = 3'd0;
    run(2, T_TIE, 1'b1, "play_loc0");

    // Game over, P1 wins; P2 changes mid-blink without relatching
    SCREEN = 3'b100;
    set_scores(12'h063, 12'h058);
    run(500, T_P1, 1'b1, "go_on");
    run(250, T_P1, 1'b0, "go_off");
    set_scores(12'h063, 12'h099);
    run(250, T_P1, 1'b0, "go_off_p2chg");
    run(10, T_P1, 1'b1, "go_on2");

    // Tie with a bad BCD digit entered mid-blink
    SCREEN = 3'b001;
    run(1, T_TIE, 1'b1, "tie_leave");
    SCREEN = 3'b100;
    set_scores(12'h040, 12'h040);
    run(500, T_TIE, 1'b1, "tie_on");
    run(500, T_TIE, 1'b0, "tie_off");
    run(3, T_TIE, 1'b1, "tie_on2");
    P1_1 = 4'd12;
    run(8, T_TIE, 1'b1, "tie_badbcd");
    run(489, T_TIE, 1'b1, "tie_on2_rest");
    run(100, T_TIE, 1'b0, "tie_off2");

    // Re-entry from the OFF phase after one countdown cycle
    SCREEN = 3'b001;
    run(1, T_TIE, 1'b1, "re_leave");
    SCREEN = 3'b100;
    set_scores(12'h100, 12'h099);
    run(500, T_P1, 1'b1, "re_on");
    run(250, T_P1, 1'b0, "re_off");

    // Reset at blink counter 250, then fresh entry with P2 ahead
    RESETN = 1'b0;
    set_scores(12'h100, 12'h200);
    tick();
    check("mid_rst_com", SEG_COM, 8'hFF);
    check("mid_rst_data", SEG_DATA, 8'h00);
    check("mid_rst_led", LED, 8'h00);
    RESETN = 1'b1;
    run(500, T_P2, 1'b1, "rst_go_on");
    run(2, T_P2, 1'b0, "rst_go_off");

    // Unknown screen code blanks everything
    SCREEN = 3'b011;
    run(8, T_P2, 1'b1, "bad_screen");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
